// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and the future receiver.
//   uart_state_e     : frame state machine encoding (IDLE, START, DATA, PARITY, STOP)
//   CLKS_PER_BIT_DEF : default bit period in clk cycles (50 MHz clock, 9600 baud)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEF = 5208;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period counter for the UART.
// Counts clk cycles and emits a one-cycle tick on the last cycle of every bit
// period, then wraps. 'clear' restarts the period so that the first bit of an
// accepted frame lasts exactly CLKS_PER_BIT cycles.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clear : restart the bit period
//   tick  : high on the last cycle of each bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT clk cycles.
// Optional feature: define UART_TX_PARITY_EN to add the parity_odd port and
// the PARITY state (parity bit = XOR of data bits XOR parity_odd).
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, highest priority
//   tx_start   : frame request, sampled only while tx_ready=1
//   data_in    : payload, captured on acceptance
//   parity_odd : 1 = odd, 0 = even parity (UART_TX_PARITY_EN only)
//   txd        : registered serial line, idle high
//   tx_ready   : high in IDLE
//   tx_done    : one-cycle pulse on the last cycle of a frame
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data_in,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              txd,
  output logic              tx_ready,
  output logic              tx_done
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              txd_q, txd_d;
  logic              accept;
  logic              done;
  logic              tick;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  // txd_d is the line value for the state being entered, so the registered
  // txd changes on the same edge as the state and never glitches.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    accept    = 1'b0;
    done      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_start) begin
          accept    = 1'b1;
          state_d   = START;
          shift_d   = data_in;
          bit_cnt_d = '0;
          txd_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^data_in) ^ parity_odd;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            txd_d     = parity_q;
`else
            state_d   = STOP;
            txd_d     = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            done      = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_done  = done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg -- scoreboard bench for uart_tx_cfg (CLKS_PER_BIT=4, 20 ns clk).
// Stimulus pushes each accepted payload into exp_q; a monitor on the falling
// edge detects start bits, pops the payload and checks every cycle of the
// frame against the bit sequence derived from the frame format.
module tb_uart_tx_cfg;

  localparam int C  = 4;
  localparam int DW = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = 1 + DW + PAR + SB;
  localparam int FRAME      = FRAME_BITS * C;

  typedef struct {
    logic [DW-1:0] data;
    logic          odd;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start;
  logic [DW-1:0] data_in;
  logic          parity_odd;
  logic          txd, tx_ready, tx_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int n_sent   = 0;
  int n_abort  = 0;

  frame_t exp_q[$];
  int     start_q[$];
  frame_t cur;
  bit     in_frame = 1'b0;
  int     k = 0;

  uart_tx_cfg #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(C),
    .STOP_BITS   (SB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .data_in   (data_in),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .txd       (txd),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Line level of bit 'idx' of a frame: start, data LSB first, parity, stops.
  function automatic logic expected_bit(input frame_t f, input int idx);
    if (idx == 0)                   return 1'b0;
    if (idx <= DW)                  return f.data[idx-1];
    if (PAR == 1 && idx == DW + 1)  return (^f.data) ^ f.odd;
    return 1'b1;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      in_frame = 1'b0;
      exp_q.delete();
    end else begin
      if (!in_frame && txd === 1'b0) begin
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          k        = 0;
          start_q.push_back(cyc);
        end
      end
      if (in_frame) begin
        check("txd_bit", 32'(txd), 32'(expected_bit(cur, k / C)));
        check("tx_done_timing", 32'(tx_done), 32'(k == FRAME - 1));
        check("tx_ready_busy", 32'(tx_ready), 32'd0);
        k++;
        if (k == FRAME) in_frame = 1'b0;
      end else begin
        check("idle_ready", 32'(tx_ready), 32'd1);
        check("idle_done", 32'(tx_done), 32'd0);
      end
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  // Waits for tx_ready, issues a request and returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic odd, input bit hold);
    frame_t f;
    int n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_timeout", 32'(tx_ready), 32'd1);
    tx_start   = 1'b1;
    data_in    = d;
    parity_odd = odd;
    f.data     = d;
    f.odd      = odd;
    exp_q.push_back(f);
    n_sent++;
    @(posedge clk); #1;
    if (!hold) tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || tx_ready !== 1'b1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle_timeout", 32'(n < 2000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int d0;
    rst        = 1'b1;
    tx_start   = 1'b0;
    data_in    = '0;
    parity_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_done", 32'(tx_done), 32'd0);
    rst = 1'b0;

    // Idle for 100 cycles: monitor checks every cycle.
    repeat (100) @(posedge clk);
    #1;

    // Basic frame and parity variants.
    send(8'hAA, 1'b0, 1'b0);
    wait_idle();
    send(8'hAA, 1'b1, 1'b0);
    wait_idle();

    // Back-to-back with tx_start held: 0x55 then 0x0F, one idle cycle between.
    n0 = start_q.size();
    d0 = done_cnt;
    send(8'h55, 1'b0, 1'b1);
    data_in = 8'h0F;
    begin
      frame_t f;
      f.data = 8'h0F;
      f.odd  = parity_odd;
      exp_q.push_back(f);
      n_sent++;
    end
    repeat (FRAME + 1) @(posedge clk);
    #1;
    tx_start = 1'b0;
    data_in  = 8'h00;
    wait_idle();
    check("b2b_frames", 32'(start_q.size() - n0), 32'd2);
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
    if (start_q.size() >= n0 + 2)
      check("b2b_gap", 32'(start_q[n0+1] - start_q[n0]), 32'(FRAME + 1));

    // Ignored request during the data phase.
    n0 = start_q.size();
    send(8'hAA, 1'b0, 1'b0);
    repeat (4 * C + 1) @(posedge clk);
    #1;
    tx_start = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk); #1;
    tx_start = 1'b0;
    data_in  = 8'h00;
    wait_idle();
    repeat (FRAME) @(posedge clk);
    #1;
    check("ignored_no_new_frame", 32'(start_q.size() - n0), 32'd1);

    // Reset mid-frame: abort, no tx_done, then a clean 0x3C frame.
    send(8'hAA, 1'b0, 1'b0);
    repeat (6 * C) @(posedge clk);
    #1;
    d0  = done_cnt;
    rst = 1'b1;
    n_abort++;
    @(posedge clk); #1;
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    repeat (FRAME) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    send(8'h3C, 1'b1, 1'b0);
    wait_idle();

    // Reset wins over a simultaneous tx_start.
    n0       = start_q.size();
    rst      = 1'b1;
    tx_start = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk); #1;
    rst      = 1'b0;
    tx_start = 1'b0;
    check("rst_prio_ready", 32'(tx_ready), 32'd1);
    check("rst_prio_txd", 32'(txd), 32'd1);
    repeat (2 * C) @(posedge clk);
    #1;
    check("rst_prio_no_frame", 32'(start_q.size() - n0), 32'd0);

    // Randomised frames with random gaps.
    for (int i = 0; i < 8; i++) begin
      send(DW'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    wait_idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("total_done_pulses", 32'(done_cnt), 32'(n_sent - n_abort));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
